mc_array_arb: RTL and testbench
===============================

MC_ARRAY_ARB -- requirements
Module: mc_array_arb

Interface
REQ-001 SHALL have parameter ARRAY_RADDR_WIDTH, default 14, array row address width.
REQ-002 SHALL have parameter ARRAY_CADDR_WIDTH, default 6, array column address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rstn  in  1  async active-low reset.
- mc_rf_start_time_cfg  in  28  cycles from reset release to first refresh request.
- mc_rf_period_time_cfg  in  28  cycles between refresh requests.
- acc_req  in  1  access engine requests array; held until acc_gnt.
- acc_gnt  out  1  one-cycle grant pulse.
- acc_done  in  1  one-cycle pulse, access engine releases array.
- acc_bank_sel_n, acc_raddr, acc_caddr  in  1/RADDR/CADDR  access-side array drive.
- rf_start  out  1  one-cycle pulse to refresh controller.
- rf_finish  in  1  one-cycle pulse, refresh sequence complete.
- rf_bank_sel_n, rf_raddr  in  1/RADDR  refresh-side array drive.
- array_bank_sel_n, array_raddr, array_caddr  out  1/RADDR/CADDR  muxed array drive.
- rf_pending  out  1  refresh owed, not yet started.
- rf_miss_cnt  out  8  missed refresh intervals (REQ-020).

Function
REQ-004 Timer SHALL load mc_rf_start_time_cfg at reset release, decrement by 1 per cycle, and on reaching 0 set rf_pending and reload mc_rf_period_time_cfg.
REQ-005 Config value 0 SHALL be treated as 1 (expiry every cycle); config is sampled only at load.
REQ-006 FSM states SHALL be IDLE, ACC, RF_GO, RF.
REQ-007 IDLE: if rf_pending -> RF_GO; else if acc_req -> ACC with acc_gnt=1 that cycle transition; refresh wins simultaneous requests.
REQ-008 RF_GO SHALL last exactly one cycle, assert rf_start, clear rf_pending, -> RF.
REQ-009 RF: hold until rf_finish, then -> IDLE; acc_req SHALL not be granted during RF_GO/RF.
REQ-010 ACC: hold until acc_done, then -> IDLE; refresh SHALL never preempt an access; rf_pending stays set while waiting.
REQ-011 Grant latency from acc_req with no pending refresh in IDLE SHALL be 1 cycle (acc_gnt registered).
REQ-012 Mux: ACC selects acc_* inputs; RF_GO/RF select rf_* inputs; IDLE drives array_bank_sel_n=1, addresses 0.
REQ-013 acc_done outside ACC and rf_finish outside RF SHALL be ignored.
REQ-014 Timer expiry coinciding with rf_pending already set SHALL increment rf_miss_cnt (saturate 255), pending stays 1.
REQ-015 Timer expiry in the same cycle as RF_GO clears pending SHALL leave rf_pending=1 (set wins), no miss counted.

Reset
REQ-016 On rstn low: FSM IDLE, timer = mc_rf_start_time_cfg, rf_pending=0, acc_gnt=0, rf_start=0, rf_miss_cnt=0, array_bank_sel_n=1, array_raddr=0, array_caddr=0.
REQ-017 Reset mid-access or mid-refresh SHALL abort immediately with no completion pulse expected.

Configuration
REQ-018 Macro MC_RF_MISS_CNT_EN compiles in the miss counter.
REQ-019 With MC_RF_MISS_CNT_EN defined: rf_miss_cnt behaves per REQ-014.
REQ-020 Without it: rf_miss_cnt tied to 0, counter logic absent; all other behaviour identical.

Structure
REQ-021 Shared package mc_pkg SHALL hold FSM state encoding (2-bit) and the 28-bit timer width constant.
REQ-022 Timer (REQ-004/005) SHALL be sub-module mc_rf_timer with outputs expire pulse only.

Verification
REQ-023 start=20, period=100, no acc_req -> rf_start pulses at cycles 21, 121, 221 after reset release (±1 fixed offset, consistent).
REQ-024 acc_req and timer expiry same cycle in IDLE -> rf_start first, acc_gnt only one cycle after rf_finish.
REQ-025 Access granted, expiry occurs, acc_done 30 cycles later -> rf_pending=1 throughout, rf_start one cycle after IDLE re-entry.
REQ-026 period=5, rf_finish held off 20 cycles -> rf_miss_cnt=3 or 4 per expiry count with macro; 0 without.
REQ-027 rstn low during RF state -> next cycle outputs at REQ-016 values; timer restarts from start_time.
REQ-028 Spurious acc_done in IDLE, rf_finish in ACC -> no state change, mux unchanged.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the memory-controller array arbiter: state encoding,
// refresh timer width and the zero-means-one config helper.
package mc_pkg;

   localparam int MC_TIMER_W = 28;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_RF_GO = 2'd2,
      ST_RF    = 2'd3
   } mc_state_e;

   // A zero interval would never expire, so it behaves as one cycle.
   function automatic logic [MC_TIMER_W-1:0] eff_cfg(input logic [MC_TIMER_W-1:0] cfg);
      return (cfg == '0) ? MC_TIMER_W'(1) : cfg;
   endfunction

endpackage

// File: rtl/mc_rf_timer.sv
// Refresh interval timer: counts down from the start interval after reset,
// then from the period interval, emitting a one-cycle expire pulse each time.
module mc_rf_timer
   import mc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [MC_TIMER_W-1:0] i_start_cfg,
   input  logic [MC_TIMER_W-1:0] i_period_cfg,
   output logic                  o_expire
);

   logic [MC_TIMER_W-1:0] r_cnt;

   // The counter never holds 0; a value of 1 marks the cycle that reaches 0.
   assign o_expire = (r_cnt == MC_TIMER_W'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= eff_cfg(i_start_cfg);
      end else if (o_expire) begin
         r_cnt <= eff_cfg(i_period_cfg);
      end else begin
         r_cnt <= r_cnt - MC_TIMER_W'(1);
      end
   end

endmodule

// File: rtl/mc_array_arb.sv
// Arbitrates the memory array between the access engine and the refresh
// controller. Define MC_RF_MISS_CNT_EN to build in the missed-refresh counter.
module mc_array_arb
   import mc_pkg::*;
#(
   parameter int ARRAY_RADDR_WIDTH = 14,
   parameter int ARRAY_CADDR_WIDTH = 6
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [MC_TIMER_W-1:0]        mc_rf_start_time_cfg,
   input  logic [MC_TIMER_W-1:0]        mc_rf_period_time_cfg,
   input  logic                         acc_req,
   output logic                         acc_gnt,
   input  logic                         acc_done,
   input  logic                         acc_bank_sel_n,
   input  logic [ARRAY_RADDR_WIDTH-1:0] acc_raddr,
   input  logic [ARRAY_CADDR_WIDTH-1:0] acc_caddr,
   output logic                         rf_start,
   input  logic                         rf_finish,
   input  logic                         rf_bank_sel_n,
   input  logic [ARRAY_RADDR_WIDTH-1:0] rf_raddr,
   output logic                         array_bank_sel_n,
   output logic [ARRAY_RADDR_WIDTH-1:0] array_raddr,
   output logic [ARRAY_CADDR_WIDTH-1:0] array_caddr,
   output logic                         rf_pending,
   output logic [7:0]                   rf_miss_cnt
);

   mc_state_e r_state;
   mc_state_e w_state_nxt;
   logic      w_gnt_nxt;
   logic      w_expire;
   logic      w_rf_clr;
   logic      r_rf_pending;
   logic      r_acc_gnt;

   mc_rf_timer u_timer (
      .clk          (clk),
      .rstn         (rstn),
      .i_start_cfg  (mc_rf_start_time_cfg),
      .i_period_cfg (mc_rf_period_time_cfg),
      .o_expire     (w_expire)
   );

   // Refresh has priority in IDLE; an access in progress is never preempted.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_rf_pending) begin
               w_state_nxt = ST_RF_GO;
            end else if (acc_req) begin
               w_state_nxt = ST_ACC;
               w_gnt_nxt   = 1'b1;
            end
         end
         ST_RF_GO: w_state_nxt = ST_RF;
         ST_RF:    if (rf_finish) w_state_nxt = ST_IDLE;
         ST_ACC:   if (acc_done)  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= ST_IDLE;
         r_acc_gnt <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc_gnt <= w_gnt_nxt;
      end
   end

   assign w_rf_clr = (r_state == ST_RF_GO);

   // A new expiry in the clearing cycle must not be lost, so set wins.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rf_pending <= 1'b0;
      end else if (w_expire) begin
         r_rf_pending <= 1'b1;
      end else if (w_rf_clr) begin
         r_rf_pending <= 1'b0;
      end
   end

`ifdef MC_RF_MISS_CNT_EN
   logic [7:0] r_miss_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_miss_cnt <= 8'd0;
      end else if (w_expire && r_rf_pending && !w_rf_clr && (r_miss_cnt != 8'hFF)) begin
         r_miss_cnt <= r_miss_cnt + 8'd1;
      end
   end

   assign rf_miss_cnt = r_miss_cnt;
`else
   assign rf_miss_cnt = 8'd0;
`endif

   always_comb begin
      array_bank_sel_n = 1'b1;
      array_raddr      = '0;
      array_caddr      = '0;
      case (r_state)
         ST_ACC: begin
            array_bank_sel_n = acc_bank_sel_n;
            array_raddr      = acc_raddr;
            array_caddr      = acc_caddr;
         end
         ST_RF_GO, ST_RF: begin
            array_bank_sel_n = rf_bank_sel_n;
            array_raddr      = rf_raddr;
         end
         default: ;
      endcase
   end

   assign acc_gnt    = r_acc_gnt;
   assign rf_start   = (r_state == ST_RF_GO);
   assign rf_pending = r_rf_pending;

endmodule

// File: tb/tb_mc_array_arb.sv
// Bench for mc_array_arb: ownership/refresh-schedule model checked every cycle,
// plus directed scenarios with hand-computed pulse times and counts.
module tb_mc_array_arb;

   localparam int RW = 14;
   localparam int CW = 6;
`ifdef MC_RF_MISS_CNT_EN
   localparam int MISS_ON = 1;
`else
   localparam int MISS_ON = 0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic [27:0]   start_cfg = 28'd20;
   logic [27:0]   period_cfg = 28'd100;
   logic          acc_req = 1'b0;
   logic          acc_done = 1'b0;
   logic          acc_bank_sel_n = 1'b0;
   logic [RW-1:0] acc_raddr = 14'h1234;
   logic [CW-1:0] acc_caddr = 6'h2A;
   logic          rf_bank_sel_n = 1'b0;
   logic [RW-1:0] rf_raddr = 14'h0ABC;
   logic          rf_finish;
   logic          man_fin = 1'b0;
   logic          auto_pulse = 1'b0;
   logic          auto_en = 1'b0;
   int            auto_cnt = 0;
   logic          acc_gnt, rf_start, rf_pending, array_bank_sel_n;
   logic [RW-1:0] array_raddr;
   logic [CW-1:0] array_caddr;
   logic [7:0]    rf_miss_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   logic chk_en = 1'b0;
   int rel_cyc;
   int rf_q[$];
   int gnt_q[$];

   always #5 clk = ~clk;
   assign rf_finish = man_fin | auto_pulse;

   mc_array_arb #(.ARRAY_RADDR_WIDTH(RW), .ARRAY_CADDR_WIDTH(CW)) dut (
      .clk                   (clk),
      .rstn                  (rstn),
      .mc_rf_start_time_cfg  (start_cfg),
      .mc_rf_period_time_cfg (period_cfg),
      .acc_req               (acc_req),
      .acc_gnt               (acc_gnt),
      .acc_done              (acc_done),
      .acc_bank_sel_n        (acc_bank_sel_n),
      .acc_raddr             (acc_raddr),
      .acc_caddr             (acc_caddr),
      .rf_start              (rf_start),
      .rf_finish             (rf_finish),
      .rf_bank_sel_n         (rf_bank_sel_n),
      .rf_raddr              (rf_raddr),
      .array_bank_sel_n      (array_bank_sel_n),
      .array_raddr           (array_raddr),
      .array_caddr           (array_caddr),
      .rf_pending            (rf_pending),
      .rf_miss_cnt           (rf_miss_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s rel=%0d got=%h want=%h", nm, rel_cyc, act, exp);
   endtask

   function automatic int q_at(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // Cycles since reset release; edge k makes rel_cyc == k.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) rel_cyc <= 0;
      else       rel_cyc <= rel_cyc + 1;
   end

   always @(negedge clk) begin
      if (rstn) begin
         if (rf_start) rf_q.push_back(rel_cyc);
         if (acc_gnt)  gnt_q.push_back(rel_cyc);
      end
   end

   // Optional refresh-controller stand-in: finish a refresh a few cycles after it starts.
   always @(posedge clk) begin
      #1;
      auto_pulse = 1'b0;
      if (!rstn) auto_cnt = 0;
      else if (auto_cnt > 0) begin
         auto_cnt--;
         if (auto_cnt == 0) auto_pulse = 1'b1;
      end else if (auto_en && rf_start) auto_cnt = 3;
   end

   // Model: who owns the array, when the refresh schedule falls due, what is owed.
   typedef enum int {O_IDLE, O_ACC, O_RFGO, O_RF} own_e;
   own_e   m_own;
   bit     m_pend, m_gnt;
   int     m_miss;
   longint m_since, m_next;

   function automatic longint eff(input logic [27:0] c);
      return (c == 28'd0) ? 64'd1 : longint'(c);
   endfunction

   always @(posedge clk or negedge rstn) begin
      own_e nxt;
      bit   due, taking;
      if (!rstn) begin
         m_own = O_IDLE; m_pend = 0; m_gnt = 0; m_miss = 0;
         m_since = 0; m_next = eff(start_cfg);
      end else begin
         m_since++;
         due = (m_since == m_next);
         if (due) m_next = m_since + eff(period_cfg);
         taking = (m_own == O_RFGO);
         nxt = m_own;
         m_gnt = 0;
         case (m_own)
            O_IDLE: if (m_pend) nxt = O_RFGO;
                    else if (acc_req) begin nxt = O_ACC; m_gnt = 1; end
            O_RFGO: nxt = O_RF;
            O_RF:   if (rf_finish) nxt = O_IDLE;
            O_ACC:  if (acc_done) nxt = O_IDLE;
         endcase
         if (MISS_ON != 0 && due && m_pend && !taking && m_miss < 255) m_miss++;
         if (due) m_pend = 1;
         else if (taking) m_pend = 0;
         m_own = nxt;
      end
   end

   always @(negedge clk) begin
      logic ebs;
      logic [RW-1:0] era;
      logic [CW-1:0] eca;
      if (chk_en) begin
         ebs = 1'b1; era = '0; eca = '0;
         if (m_own == O_ACC) begin
            ebs = acc_bank_sel_n; era = acc_raddr; eca = acc_caddr;
         end else if (m_own == O_RFGO || m_own == O_RF) begin
            ebs = rf_bank_sel_n; era = rf_raddr;
         end
         chk("cycle",
             64'({acc_gnt, rf_start, rf_pending, array_bank_sel_n, array_raddr, array_caddr, rf_miss_cnt}),
             64'({m_gnt, (m_own == O_RFGO), m_pend, ebs, era, eca, 8'(m_miss)}));
      end
   end

   task automatic wait_rel(input int n);
      while (rel_cyc < n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic at_rel(input int n);
      wait_rel(n);
      @(negedge clk);
   endtask

   task automatic do_reset(input logic [27:0] s, input logic [27:0] p);
      @(posedge clk); #1;
      start_cfg = s; period_cfg = p;
      acc_req = 0; acc_done = 0; man_fin = 0; auto_en = 0;
      rstn = 0;
      chk_en = 1;
      rf_q.delete(); gnt_q.delete();
      @(negedge clk);
      chk("reset_vals",
          64'({acc_gnt, rf_start, rf_pending, array_bank_sel_n, array_raddr, array_caddr, rf_miss_cnt}),
          64'({3'b000, 1'b1, {RW{1'b0}}, {CW{1'b0}}, 8'd0}));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstn = 1;
   endtask

   task automatic pulse_at(input int n, input int which);
      wait_rel(n);
      if (which == 0) acc_done = 1; else man_fin = 1;
      wait_rel(n + 1);
      acc_done = 0; man_fin = 0;
   endtask

   initial begin
      // Periodic refresh with no access traffic.
      do_reset(28'd20, 28'd100);
      auto_en = 1;
      at_rel(230);
      chk("t1_count", 64'(rf_q.size()), 64'd3);
      chk("t1_rf0", 64'(q_at(rf_q, 0)), 64'd21);
      chk("t1_rf1", 64'(q_at(rf_q, 1)), 64'd121);
      chk("t1_rf2", 64'(q_at(rf_q, 2)), 64'd221);

      // Request arriving with the refresh; spurious completions.
      do_reset(28'd10, 28'd1000);
      wait_rel(10); acc_req = 1;
      pulse_at(15, 1);
      wait_rel(17); acc_req = 0;
      pulse_at(20, 0);
      pulse_at(25, 0);
      wait_rel(30); acc_req = 1;
      wait_rel(31); acc_req = 0;
      pulse_at(33, 1);
      at_rel(35);
      chk("t2_mux_raddr", 64'(array_raddr), 64'h1234);
      chk("t2_mux_bs", 64'(array_bank_sel_n), 64'd0);
      wait_rel(35); acc_raddr = 14'h0777; acc_caddr = 6'h15;
      pulse_at(36, 0);
      chk("t2_rf0", 64'(q_at(rf_q, 0)), 64'd11);
      chk("t2_gnt0", 64'(q_at(gnt_q, 0)), 64'd17);
      chk("t2_gnt1", 64'(q_at(gnt_q, 1)), 64'd31);

      // Expiry during a long access.
      do_reset(28'd10, 28'd1000);
      wait_rel(2); acc_req = 1;
      wait_rel(3); acc_req = 0;
      at_rel(30);
      chk("t3_pending", 64'(rf_pending), 64'd1);
      pulse_at(40, 0);
      pulse_at(45, 1);
      chk("t3_gnt0", 64'(q_at(gnt_q, 0)), 64'd3);
      chk("t3_rf0", 64'(q_at(rf_q, 0)), 64'd42);

      // Short period with a slow refresh: missed intervals.
      do_reset(28'd5, 28'd5);
      pulse_at(26, 1);
      at_rel(27);
      chk("t4_miss", 64'(rf_miss_cnt), 64'(3 * MISS_ON));
      pulse_at(31, 1);
      auto_en = 1;
      wait_rel(60);

      // Expiry coinciding with the pending clear, then reset during refresh.
      do_reset(28'd3, 28'd1);
      at_rel(5);
      chk("t5_pend_setwins", 64'({rf_pending, rf_start, rf_miss_cnt}), 64'({2'b10, 8'd0}));
      at_rel(6);
      chk("t5_miss", 64'(rf_miss_cnt), 64'(MISS_ON));
      wait_rel(8);
      do_reset(28'd4, 28'd50);
      auto_en = 1;
      at_rel(60);
      chk("t6_rf0", 64'(q_at(rf_q, 0)), 64'd5);
      chk("t6_rf1", 64'(q_at(rf_q, 1)), 64'd55);

      // Zero configs act as one; saturating miss count.
      do_reset(28'd0, 28'd0);
      at_rel(300);
      chk("t7_rf0", 64'(q_at(rf_q, 0)), 64'd2);
      chk("t7_sat", 64'(rf_miss_cnt), 64'(255 * MISS_ON));
      pulse_at(301, 1);
      auto_en = 1;
      wait_rel(330);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog rel=%0d got=timeout want=finish", rel_cyc);
      $fatal(1, "watchdog");
   end

endmodule
